// File: rtl/mmpu_op_issuer.sv
// Crossbar row-vector instruction issuer: validates one operation, broadcasts its
// fields to the bitline decoders, and sequences SETUP -> APPLY -> RECOVER.
module mmpu_op_issuer #(
  parameter int dest_size    = 10,
  parameter int src_size     = 10,
  parameter int pulse_cycles = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mem_op,
  input  logic                 in_col_flag,
  input  logic [dest_size-1:0] in_dest,
  input  logic [src_size-1:0]  in_src1,
  input  logic [src_size-1:0]  in_src2,
  input  logic [src_size-1:0]  in_start,
  input  logic [src_size-1:0]  in_endx,
  output logic [1:0]           mem_op,
  output logic                 col_flag,
  output logic [dest_size-1:0] dest_addr,
  output logic [src_size-1:0]  src1_addr,
  output logic [src_size-1:0]  src2_addr,
  output logic [src_size-1:0]  start,
  output logic [src_size-1:0]  endx,
  output logic                 apply_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, SETUP, APPLY, RECOVER} state_t;

  typedef struct packed {
    logic [1:0]           mem_op;
    logic                 col_flag;
    logic [dest_size-1:0] dest;
    logic [src_size-1:0]  src1;
    logic [src_size-1:0]  src2;
    logic [src_size-1:0]  start;
    logic [src_size-1:0]  endx;
  } fields_t;

  // start > endx is an empty row range, so every decoder selects isolate.
  localparam fields_t IDLE_FIELDS = '{
    mem_op: 2'b00, col_flag: 1'b0, dest: '0, src1: '0, src2: '0, start: '1, endx: '0
  };
  localparam logic [7:0] PULSE_LOAD = 8'(pulse_cycles - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  fields_t    fields_q, fields_d;
  logic       in_ready_q, in_ready_d;
  logic       busy_q, busy_d;
  logic       apply_en_q, apply_en_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       in_legal;
  fields_t    in_fields;

  assign in_fields = '{
    mem_op: in_mem_op, col_flag: in_col_flag, dest: in_dest,
    src1: in_src1, src2: in_src2, start: in_start, endx: in_endx
  };

  always_comb begin
    if (in_col_flag) in_legal = !in_mem_op[1] || (in_src1 <= in_src2);
    else             in_legal = (in_start <= in_endx);
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    fields_d   = fields_q;
    apply_en_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_legal) begin
            fields_d = in_fields;
            state_d  = SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d    = APPLY;
        cnt_d      = PULSE_LOAD;
        apply_en_d = 1'b1;
      end
      APPLY: begin
        if (cnt_q == 8'd0) begin
          state_d  = RECOVER;
          done_d   = 1'b1;
          fields_d = IDLE_FIELDS;
        end else begin
          cnt_d      = cnt_q - 8'd1;
          apply_en_d = 1'b1;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fields_q   <= IDLE_FIELDS;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      apply_en_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fields_q   <= fields_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      apply_en_q <= apply_en_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign apply_en  = apply_en_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_op    = fields_q.mem_op;
  assign col_flag  = fields_q.col_flag;
  assign dest_addr = fields_q.dest;
  assign src1_addr = fields_q.src1;
  assign src2_addr = fields_q.src2;
  assign start     = fields_q.start;
  assign endx      = fields_q.endx;

endmodule

// File: tb/tb_mmpu_op_issuer.sv
// Self-checking bench for mmpu_op_issuer: directed scenarios plus randomized
// instructions compared against a transaction-level timeline model.
module tb_mmpu_op_issuer;
  localparam int DS = 10;
  localparam int SS = 10;
  localparam int PC = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mem_op;
  logic          in_col_flag;
  logic [DS-1:0] in_dest;
  logic [SS-1:0] in_src1, in_src2, in_start, in_endx;
  logic [1:0]    mem_op;
  logic          col_flag;
  logic [DS-1:0] dest_addr;
  logic [SS-1:0] src1_addr, src2_addr, start, endx;
  logic          apply_en, busy, done, err;

  mmpu_op_issuer #(.dest_size(DS), .src_size(SS), .pulse_cycles(PC)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_op(in_mem_op), .in_col_flag(in_col_flag), .in_dest(in_dest),
    .in_src1(in_src1), .in_src2(in_src2), .in_start(in_start), .in_endx(in_endx),
    .mem_op(mem_op), .col_flag(col_flag), .dest_addr(dest_addr),
    .src1_addr(src1_addr), .src2_addr(src2_addr), .start(start), .endx(endx),
    .apply_en(apply_en), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]    op;
    logic          col;
    logic [DS-1:0] dest;
    logic [SS-1:0] s1, s2, st, en;
  } instr_t;

  localparam int FW = 2 + 1 + DS + 4 * SS;

  int     checks   = 0;
  int     failures = 0;
  instr_t idle_pat;
  instr_t bcast;

  function automatic logic [FW-1:0] pack(input instr_t i);
    return {i.op, i.col, i.dest, i.s1, i.s2, i.st, i.en};
  endfunction

  function automatic logic [FW-1:0] obs_fields();
    return {mem_op, col_flag, dest_addr, src1_addr, src2_addr, start, endx};
  endfunction

  // {in_ready, busy, apply_en, done, err}
  function automatic logic [4:0] obs_ctrl();
    return {in_ready, busy, apply_en, done, err};
  endfunction

  // Legality straight from the acceptance rules: ranged column ops (codes 2,3)
  // need src1 <= src2, row ops need start <= endx, everything else passes.
  function automatic bit is_legal(input instr_t i);
    if (i.col == 1'b1) begin
      if (int'(i.op) >= 2) return int'(i.s1) <= int'(i.s2);
      return 1'b1;
    end
    return int'(i.st) <= int'(i.en);
  endfunction

  task automatic drive(input instr_t i, input logic v);
    in_valid    = v;
    in_mem_op   = i.op;
    in_col_flag = i.col;
    in_dest     = i.dest;
    in_src1     = i.s1;
    in_src2     = i.s2;
    in_start    = i.st;
    in_endx     = i.en;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic instr_t mk(input int op, input int col, input int dest,
                                input int s1, input int s2, input int st, input int en);
    instr_t i;
    i.op = 2'(op); i.col = 1'(col); i.dest = DS'(dest);
    i.s1 = SS'(s1); i.s2 = SS'(s2); i.st = SS'(st); i.en = SS'(en);
    return i;
  endfunction

  // Issues one instruction and walks its whole expected timeline, comparing
  // control outputs and broadcast fields every cycle.
  task automatic run_op(input instr_t i, input string name);
    bit legal;
    legal = is_legal(i);
    drive(i, 1'b1);
    step();
    in_valid = 1'b0;
    if (!legal) begin
      checks++;
      if (obs_ctrl() !== 5'b10001) begin
        failures++;
        $display("FAIL %s err_cycle ctrl got=%b want=%b", name, obs_ctrl(), 5'b10001);
      end
      checks++;
      if (obs_fields() !== pack(bcast)) begin
        failures++;
        $display("FAIL %s err_fields got=%h want=%h", name, obs_fields(), pack(bcast));
      end
      step();
      checks++;
      if (obs_ctrl() !== 5'b10000) begin
        failures++;
        $display("FAIL %s after_err ctrl got=%b want=%b", name, obs_ctrl(), 5'b10000);
      end
      return;
    end
    bcast = i;
    checks++;
    if (obs_ctrl() !== 5'b01000) begin
      failures++;
      $display("FAIL %s setup ctrl got=%b want=%b", name, obs_ctrl(), 5'b01000);
    end
    checks++;
    if (obs_fields() !== pack(bcast)) begin
      failures++;
      $display("FAIL %s setup_fields got=%h want=%h", name, obs_fields(), pack(bcast));
    end
    for (int k = 1; k <= PC; k++) begin
      step();
      checks++;
      if (obs_ctrl() !== 5'b01100) begin
        failures++;
        $display("FAIL %s apply%0d ctrl got=%b want=%b", name, k, obs_ctrl(), 5'b01100);
      end
      checks++;
      if (obs_fields() !== pack(bcast)) begin
        failures++;
        $display("FAIL %s apply%0d_fields got=%h want=%h", name, k, obs_fields(), pack(bcast));
      end
    end
    step();
    bcast = idle_pat;
    checks++;
    if (obs_ctrl() !== 5'b01010) begin
      failures++;
      $display("FAIL %s done ctrl got=%b want=%b", name, obs_ctrl(), 5'b01010);
    end
    checks++;
    if (obs_fields() !== pack(bcast)) begin
      failures++;
      $display("FAIL %s done_fields got=%h want=%h", name, obs_fields(), pack(bcast));
    end
    step();
    checks++;
    if (obs_ctrl() !== 5'b10000) begin
      failures++;
      $display("FAIL %s ready_again ctrl got=%b want=%b", name, obs_ctrl(), 5'b10000);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(idle_pat, 1'b0);
    step();
    step();
    reset = 1'b0;
    bcast = idle_pat;
    checks++;
    if (obs_ctrl() !== 5'b10000) begin
      failures++;
      $display("FAIL reset ctrl got=%b want=%b", obs_ctrl(), 5'b10000);
    end
    checks++;
    if (obs_fields() !== pack(idle_pat)) begin
      failures++;
      $display("FAIL reset fields got=%h want=%h", obs_fields(), pack(idle_pat));
    end
    step();
    checks++;
    if (obs_ctrl() !== 5'b10000) begin
      failures++;
      $display("FAIL reset idle_hold ctrl got=%b want=%b", obs_ctrl(), 5'b10000);
    end
  endtask

  task automatic test_col_write();
    run_op(mk(1, 1, 5, 2, 3, 0, 0), "col_write");
  endtask

  task automatic test_invalid();
    run_op(mk(2, 1, 17, 9, 4, 0, 0), "invalid_range");
    run_op(mk(3, 1, 1, 20, 19, 0, 0), "invalid_range2");
    run_op(mk(2, 1, 3, 4, 4, 0, 0), "col_equal_ok");
  endtask

  task automatic test_row_boundary();
    run_op(mk(0, 0, 33, 1, 2, 7, 7), "row_equal");
    run_op(mk(0, 0, 33, 1, 2, 8, 7), "row_start_gt_end");
    run_op(mk(1, 0, 0, 0, 0, 0, 1023), "row_full");
  endtask

  task automatic test_reset_mid_apply();
    drive(mk(1, 0, 9, 0, 0, 2, 6), 1'b1);
    step();
    in_valid = 1'b0;
    step();
    step();
    checks++;
    if (apply_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_apply second_apply apply_en got=%b want=1", apply_en);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    bcast = idle_pat;
    checks++;
    if (obs_ctrl() !== 5'b10000) begin
      failures++;
      $display("FAIL reset_mid_apply ctrl got=%b want=%b", obs_ctrl(), 5'b10000);
    end
    checks++;
    if (obs_fields() !== pack(idle_pat)) begin
      failures++;
      $display("FAIL reset_mid_apply fields got=%h want=%h", obs_fields(), pack(idle_pat));
    end
    step();
    checks++;
    if (obs_ctrl() !== 5'b10000) begin
      failures++;
      $display("FAIL reset_mid_apply no_done ctrl got=%b want=%b", obs_ctrl(), 5'b10000);
    end
  endtask

  task automatic test_back_to_back();
    instr_t a, b;
    a = mk(1, 1, 5, 2, 3, 0, 0);
    b = mk(0, 0, 77, 11, 12, 3, 9);
    drive(a, 1'b1);
    step();
    drive(b, 1'b1);
    // Cycles t+1 .. t+6: busy with A, B must not be taken.
    for (int c = 1; c <= PC + 2; c++) begin
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL b2b busy_a c=%0d ready/busy got=%b%b want=01", c, in_ready, busy);
      end
      checks++;
      if (obs_fields() !== pack(c <= PC + 1 ? a : idle_pat)) begin
        failures++;
        $display("FAIL b2b fields_a c=%0d got=%h want=%h", c, obs_fields(),
                 pack(c <= PC + 1 ? a : idle_pat));
      end
      step();
    end
    // Cycle t+7: ready, B accepted at the following edge.
    checks++;
    if (obs_ctrl() !== 5'b10000) begin
      failures++;
      $display("FAIL b2b ready_cycle ctrl got=%b want=%b", obs_ctrl(), 5'b10000);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (obs_fields() !== pack(b) || obs_ctrl() !== 5'b01000) begin
      failures++;
      $display("FAIL b2b accept_b fields=%h ctrl=%b want fields=%h ctrl=%b",
               obs_fields(), obs_ctrl(), pack(b), 5'b01000);
    end
    for (int k = 0; k < PC + 2; k++) step();
    bcast = idle_pat;
    checks++;
    if (obs_ctrl() !== 5'b10000 || obs_fields() !== pack(idle_pat)) begin
      failures++;
      $display("FAIL b2b end_b ctrl=%b fields=%h want ctrl=%b fields=%h",
               obs_ctrl(), obs_fields(), 5'b10000, pack(idle_pat));
    end
  endtask

  task automatic test_random();
    instr_t i;
    for (int n = 0; n < 60; n++) begin
      i.op   = 2'($urandom_range(0, 3));
      i.col  = 1'($urandom_range(0, 1));
      i.dest = DS'($urandom);
      i.s1   = ($urandom_range(0, 1) == 1) ? SS'($urandom_range(0, 15)) : SS'($urandom);
      i.s2   = ($urandom_range(0, 1) == 1) ? SS'($urandom_range(0, 15)) : SS'($urandom);
      i.st   = ($urandom_range(0, 1) == 1) ? SS'($urandom_range(0, 15)) : SS'($urandom);
      i.en   = ($urandom_range(0, 1) == 1) ? SS'($urandom_range(0, 15)) : SS'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        drive(i, 1'b0);
        step();
        checks++;
        if (obs_ctrl() !== 5'b10000 || obs_fields() !== pack(bcast)) begin
          failures++;
          $display("FAIL random_gap n=%0d ctrl=%b fields=%h want ctrl=%b fields=%h",
                   n, obs_ctrl(), obs_fields(), 5'b10000, pack(bcast));
        end
      end
      run_op(i, $sformatf("random%0d", n));
    end
  endtask

  initial begin
    idle_pat = mk(0, 0, 0, 0, 0, 1023, 0);
    bcast    = idle_pat;
    reset    = 1'b1;
    drive(idle_pat, 1'b0);
    test_reset();
    test_col_write();
    test_invalid();
    test_row_boundary();
    test_reset_mid_apply();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
